llc_trace_stats: RTL and testbench
==================================

Name:
llc_trace_stats

Overview:
Parametrised, synthesizable cache-statistics engine fed by the LLC model's per-request outcome stream. Classifies each event as read, write or other by command code and keeps saturating counters for reads, writes, hits and misses. Computes the hit ratio in hardware with a sequential fixed-point divider. Sits beside the LLC, replacing testbench-side real-number statistics.

Parameters:
CMDSIZE, 4, width of the command code.
CNT_W, 32, width of each statistics counter.
RATIO_F, 8, fractional bits of the hit ratio. Ratio output is unsigned 1.RATIO_F.
READ_MASK, 16'h0005, bit k set means command k counts as a read (defaults: cmds 0 and 2).
WRITE_MASK, 16'h0002, bit k set means command k counts as a write (default: cmd 1).

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
evt_valid  in  1  outcome event valid
evt_ready  out  1  engine can accept an event
evt_cmd  in  CMDSIZE  command code of the event
evt_hit  in  1  1 = hit, 0 = miss; used only for read/write commands
clear_req  in  1  single-cycle request to zero all counters
calc_req  in  1  single-cycle request to compute the hit ratio
reads  out  CNT_W  read count
writes  out  CNT_W  write count
others  out  CNT_W  count of non-read/non-write events
hits  out  CNT_W  hit count
misses  out  CNT_W  miss count
ratio  out  RATIO_F+1  floor(hits*2^RATIO_F/(hits+misses))
ratio_valid  out  1  one-cycle pulse: ratio updated
div_zero  out  1  last calc had hits+misses == 0
busy  out  1  divider running
sat_flag  out  1  sticky: some counter saturated

Behaviour:
- Reset (reset_n low, asynchronous): all counters, ratio, ratio_valid, div_zero, busy and sat_flag go to 0. evt_ready goes to 1. FSM enters IDLE.
- Event accept: an event is accepted on a rising edge where evt_valid and evt_ready are both 1. Counters update at that edge and are visible in the next cycle.
- Event classification:
  - READ_MASK[evt_cmd] set: reads increments.
  - Otherwise, WRITE_MASK[evt_cmd] set: writes increments. READ_MASK has priority when both bits are set.
  - Otherwise: others increments.
  - For read or write events only: hits increments if evt_hit is 1, else misses increments.
  - Commands at or above 16 index the masks as zero.
- Saturation: a counter at all-ones holds its value. sat_flag sets on any saturated increment and clears only on clear or reset.
- clear_req:
  - Zeroes all counters, ratio, div_zero and sat_flag at the sampling edge.
  - evt_ready is combinationally 0 while clear_req is 1, so clear wins over a simultaneous event and the event stalls.
  - Clear during DIV aborts the division: FSM returns to IDLE, busy drops, and no ratio_valid pulse is produced.
- FSM states: IDLE, DIV, DONE.
  - IDLE: calc_req snapshots num = hits and den = hits + misses (CNT_W+1 bits, no overflow) at edge t.
    - If den == 0: go to DONE; ratio = 0, div_zero = 1.
    - Otherwise: go to DIV; busy = 1, div_zero = 0.
  - DIV: restoring long division of num*2^RATIO_F by den, one quotient bit per cycle, MSB first, RATIO_F+1 cycles.
  - DONE: ratio is registered and ratio_valid = 1 for exactly one cycle; busy = 0; then back to IDLE.
  - Timing for den != 0: ratio_valid is high in the cycle after edge t+RATIO_F+2.
  - Timing for den == 0: ratio_valid is high in the cycle after edge t+1.
  - calc_req outside IDLE is ignored.
- Events during DIV are accepted and counted. The snapshot is unaffected, so ratio reflects counts at edge t.
- ratio holds its value between calculations. Maximum value is 2^RATIO_F when every access hits.

Test Plan:
1. Reset, then send cmds 0 (hit), 2 (hit), 1 (hit), 1 (miss), 3, then calc_req -> reads=2, writes=2, others=1, hits=3, misses=1. ratio=0x0C0, with ratio_valid high exactly 10 cycles after the calc_req edge.
2. Send 5 read hits, then calc_req -> ratio=0x100, div_zero=0. Then clear_req and calc_req -> all counters 0, ratio=0, div_zero=1, ratio_valid 1 cycle after calc_req.
3. Set CNT_W=4 and send 17 read misses -> reads=15, misses=15, sat_flag=1. Then clear_req -> sat_flag=0.
4. Assert calc_req with 1 hit and 2 misses, then feed 4 read hits during DIV and assert a second calc_req mid-DIV -> ratio=0x055 (floor(256/3)), only one ratio_valid pulse, then hits=5.
5. Assert clear_req and evt_valid in the same cycle -> evt_ready=0, counters zero, and the event is counted the following cycle. Assert clear_req 3 cycles into DIV -> no ratio_valid, busy=0 next cycle.
6. Drop reset_n asynchronously mid-DIV with counters non-zero -> all outputs 0 immediately, evt_ready=1, FSM in IDLE.

Source files
------------

// File: rtl/llc_trace_stats_if.sv
// Event/statistics bus between the LLC outcome stream and the stats engine.
interface llc_trace_stats_if #(
   parameter int CMDSIZE = 4,
   parameter int CNT_W   = 32,
   parameter int RATIO_F = 8
);
   logic               evt_valid;
   logic               evt_ready;
   logic [CMDSIZE-1:0] evt_cmd;
   logic               evt_hit;
   logic               clear_req;
   logic               calc_req;
   logic [CNT_W-1:0]   reads;
   logic [CNT_W-1:0]   writes;
   logic [CNT_W-1:0]   others;
   logic [CNT_W-1:0]   hits;
   logic [CNT_W-1:0]   misses;
   logic [RATIO_F:0]   ratio;
   logic               ratio_valid;
   logic               div_zero;
   logic               busy;
   logic               sat_flag;

   // Event source / statistics consumer side.
   modport master (
      output evt_valid, evt_cmd, evt_hit, clear_req, calc_req,
      input  evt_ready, reads, writes, others, hits, misses,
             ratio, ratio_valid, div_zero, busy, sat_flag
   );

   // Statistics engine side.
   modport slave (
      input  evt_valid, evt_cmd, evt_hit, clear_req, calc_req,
      output evt_ready, reads, writes, others, hits, misses,
             ratio, ratio_valid, div_zero, busy, sat_flag
   );
endinterface

// File: rtl/llc_trace_stats.sv
// LLC outcome statistics: saturating read/write/other/hit/miss counters and a
// sequential restoring divider producing hit ratio as unsigned 1.RATIO_F.
module llc_trace_stats #(
   parameter int          CMDSIZE    = 4,
   parameter int          CNT_W      = 32,
   parameter int          RATIO_F    = 8,
   parameter logic [15:0] READ_MASK  = 16'h0005,
   parameter logic [15:0] WRITE_MASK = 16'h0002
) (
   input logic                clk,
   input logic                reset_n,
   llc_trace_stats_if.slave   bus
);
   localparam int DEN_W = CNT_W + 1;               // hits+misses without overflow
   localparam int REM_W = CNT_W + 2;               // remainder < den, shifted left once
   localparam int CW    = $clog2(RATIO_F + 2);
   localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
   localparam logic [CW-1:0]    LAST_B = CW'(RATIO_F);

   typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + ONE;
   endfunction

   state_t             r_state;
   logic [CNT_W-1:0]   r_reads, r_writes, r_others, r_hits, r_misses;
   logic               r_sat;
   logic [DEN_W-1:0]   r_den;
   logic [REM_W-1:0]   r_rem;
   logic [RATIO_F:0]   r_quot;
   logic [CW-1:0]      r_cnt;
   logic [RATIO_F:0]   r_ratio;
   logic               r_ratio_valid;
   logic               r_div_zero;
   logic               r_busy;

   logic [31:0]        w_cmd_ext;
   logic               w_in_range;
   logic               w_accept;
   logic               w_is_rd, w_is_wr, w_is_oth, w_is_rw;
   logic               w_sat_ev;
   logic [DEN_W-1:0]   w_den;
   logic               w_ge;
   logic [REM_W-1:0]   w_diff;

   // Clear stalls the event stream so it always wins over a same-cycle event.
   assign bus.evt_ready = ~bus.clear_req;
   assign w_accept      = bus.evt_valid & ~bus.clear_req;

   // Commands beyond the 16-entry masks classify as "other".
   assign w_cmd_ext  = 32'(bus.evt_cmd);
   assign w_in_range = (w_cmd_ext < 32'd16);
   assign w_is_rd    = w_in_range & READ_MASK[w_cmd_ext[3:0]];
   assign w_is_wr    = w_in_range & ~w_is_rd & WRITE_MASK[w_cmd_ext[3:0]];
   assign w_is_oth   = ~w_is_rd & ~w_is_wr;
   assign w_is_rw    = w_is_rd | w_is_wr;

   // Any increment landing on an all-ones counter is a saturation event.
   assign w_sat_ev = (w_is_rd  & (&r_reads))  |
                     (w_is_wr  & (&r_writes)) |
                     (w_is_oth & (&r_others)) |
                     (w_is_rw  & ( bus.evt_hit & (&r_hits))) |
                     (w_is_rw  & (~bus.evt_hit & (&r_misses)));

   assign w_den  = {1'b0, r_hits} + {1'b0, r_misses};
   assign w_ge   = (r_rem >= REM_W'(r_den));
   assign w_diff = r_rem - REM_W'(r_den);

   // Event counters and sticky saturation flag.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_reads  <= '0;
         r_writes <= '0;
         r_others <= '0;
         r_hits   <= '0;
         r_misses <= '0;
         r_sat    <= 1'b0;
      end else if (bus.clear_req) begin
         r_reads  <= '0;
         r_writes <= '0;
         r_others <= '0;
         r_hits   <= '0;
         r_misses <= '0;
         r_sat    <= 1'b0;
      end else if (w_accept) begin
         if (w_is_rd)  r_reads  <= sat_inc(r_reads);
         if (w_is_wr)  r_writes <= sat_inc(r_writes);
         if (w_is_oth) r_others <= sat_inc(r_others);
         if (w_is_rw) begin
            if (bus.evt_hit) r_hits   <= sat_inc(r_hits);
            else             r_misses <= sat_inc(r_misses);
         end
         if (w_sat_ev) r_sat <= 1'b1;
      end
   end

   // Ratio FSM: snapshot on calc, one quotient bit per DIV cycle, publish in DONE.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state       <= S_IDLE;
         r_den         <= '0;
         r_rem         <= '0;
         r_quot        <= '0;
         r_cnt         <= '0;
         r_ratio       <= '0;
         r_ratio_valid <= 1'b0;
         r_div_zero    <= 1'b0;
         r_busy        <= 1'b0;
      end else begin
         r_ratio_valid <= 1'b0;
         if (bus.clear_req) begin
            // Abort any calculation in flight; no ratio_valid follows.
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_ratio    <= '0;
            r_div_zero <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (bus.calc_req) begin
                     r_den  <= w_den;
                     r_rem  <= REM_W'(r_hits);
                     r_quot <= '0;
                     r_cnt  <= '0;
                     if (w_den == '0) begin
                        r_state    <= S_DONE;
                        r_div_zero <= 1'b1;
                     end else begin
                        r_state    <= S_DIV;
                        r_busy     <= 1'b1;
                        r_div_zero <= 1'b0;
                     end
                  end
               end
               S_DIV: begin
                  // num <= den, so the first step needs no pre-shift; the low
                  // dividend bits are all zero, so each step just shifts in 0.
                  r_quot <= {r_quot[RATIO_F-1:0], w_ge};
                  r_rem  <= w_ge ? REM_W'({w_diff, 1'b0}) : REM_W'({r_rem, 1'b0});
                  r_cnt  <= r_cnt + CW'(1);
                  if (r_cnt == LAST_B) begin
                     r_state <= S_DONE;
                     r_busy  <= 1'b0;
                  end
               end
               S_DONE: begin
                  r_ratio       <= r_quot;
                  r_ratio_valid <= 1'b1;
                  r_state       <= S_IDLE;
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign bus.reads       = r_reads;
   assign bus.writes      = r_writes;
   assign bus.others      = r_others;
   assign bus.hits        = r_hits;
   assign bus.misses      = r_misses;
   assign bus.sat_flag    = r_sat;
   assign bus.ratio       = r_ratio;
   assign bus.ratio_valid = r_ratio_valid;
   assign bus.div_zero    = r_div_zero;
   assign bus.busy        = r_busy;
endmodule

// File: tb/tb_llc_trace_stats.sv
// Scoreboard bench: stimulus pushes expected ratio pulses, a monitor pops them.
module tb_llc_trace_stats;
   localparam int F = 8;
   localparam longint MAXC = 64'hFFFF_FFFF;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   llc_trace_stats_if #(.CMDSIZE(4), .CNT_W(32), .RATIO_F(F)) bus ();
   llc_trace_stats_if #(.CMDSIZE(4), .CNT_W(4),  .RATIO_F(F)) bus4 ();

   llc_trace_stats #(.CMDSIZE(4), .CNT_W(32), .RATIO_F(F)) dut  (.clk(clk), .reset_n(reset_n), .bus(bus));
   llc_trace_stats #(.CMDSIZE(4), .CNT_W(4),  .RATIO_F(F)) dut4 (.clk(clk), .reset_n(reset_n), .bus(bus4));

   typedef struct { longint ratio; bit dz; int cyc; } exp_t;
   exp_t sbq[$];
   exp_t mon_e;

   int vectors = 0, miscompares = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // reference model state
   longint m_rd, m_wr, m_ot, m_h, m_m;
   bit     m_sat;
   int     idle_from = 0;
   bit     pend = 0;
   int     pend_edge = 0;
   bit     bz_on = 0;
   int     bz_lo = 0, bz_hi = -1;
   logic [15:0] rdm = 16'h0005;
   logic [15:0] wrm = 16'h0002;

   task automatic chk(input string nm, input longint act, input longint exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d (cyc %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic longint sinc(input longint c);
      if (c >= MAXC) begin m_sat = 1; return c; end
      return c + 1;
   endfunction

   function automatic bit exp_busy();
      return bz_on && (cyc >= bz_lo) && (cyc <= bz_hi);
   endfunction

   task automatic model_zero();
      m_rd = 0; m_wr = 0; m_ot = 0; m_h = 0; m_m = 0; m_sat = 0;
   endtask

   // Monitor: busy every cycle, ratio pulses against the scoreboard queue.
   always @(negedge clk) begin
      if (reset_n) begin
         chk("busy", bus.busy, exp_busy());
         if (bus.ratio_valid) begin
            if (sbq.size() == 0) chk("spurious_ratio_valid", 1, 0);
            else begin
               mon_e = sbq.pop_front();
               chk("ratio", bus.ratio, mon_e.ratio);
               chk("div_zero", bus.div_zero, mon_e.dz);
               chk("pulse_cycle", cyc, mon_e.cyc);
            end
         end else if (sbq.size() > 0 && cyc > sbq[0].cyc) begin
            chk("ratio_valid_timeout", 0, 1);
            void'(sbq.pop_front());
         end
      end
   end

   // One clock of stimulus; the model applies the same edge's rules afterwards.
   task automatic step(input bit v, input logic [3:0] cmd, input bit hit,
                       input bit clr, input bit calc);
      int e;
      longint den;
      bit isr, isw;
      bus.evt_valid = v; bus.evt_cmd = cmd; bus.evt_hit = hit;
      bus.clear_req = clr; bus.calc_req = calc;
      @(posedge clk);
      #1;
      e = cyc;
      if (clr) begin
         if (pend && e <= pend_edge && sbq.size() > 0) sbq.delete(sbq.size() - 1);
         pend = 0;
         if (bz_hi > e - 1) bz_hi = e - 1;
         model_zero();
         idle_from = e + 1;
      end else begin
         if (calc && e >= idle_from) begin
            den = m_h + m_m;
            pend = 1;
            if (den == 0) begin
               sbq.push_back('{0, 1'b1, e + 1});
               pend_edge = e + 1; idle_from = e + 2;
            end else begin
               sbq.push_back('{(m_h * 256) / den, 1'b0, e + F + 2});
               pend_edge = e + F + 2; idle_from = e + F + 3;
               bz_on = 1; bz_lo = e; bz_hi = e + F;
            end
         end
         if (v) begin
            isr = rdm[cmd];
            isw = !isr && wrm[cmd];
            if (isr) m_rd = sinc(m_rd);
            else if (isw) m_wr = sinc(m_wr);
            else m_ot = sinc(m_ot);
            if (isr || isw) begin
               if (hit) m_h = sinc(m_h); else m_m = sinc(m_m);
            end
         end
      end
      bus.evt_valid = 0; bus.clear_req = 0; bus.calc_req = 0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 4'd0, 0, 0, 0);
   endtask

   task automatic chk_counts(input string t);
      chk({t, ".reads"},  bus.reads,  m_rd);
      chk({t, ".writes"}, bus.writes, m_wr);
      chk({t, ".others"}, bus.others, m_ot);
      chk({t, ".hits"},   bus.hits,   m_h);
      chk({t, ".misses"}, bus.misses, m_m);
      chk({t, ".sat"},    bus.sat_flag, m_sat);
   endtask

   task automatic step4(input bit v, input logic [3:0] cmd, input bit hit, input bit clr);
      bus4.evt_valid = v; bus4.evt_cmd = cmd; bus4.evt_hit = hit; bus4.clear_req = clr;
      @(posedge clk);
      #1;
      bus4.evt_valid = 0; bus4.clear_req = 0;
   endtask

   initial begin
      bus.evt_valid = 0; bus.evt_cmd = 0; bus.evt_hit = 0; bus.clear_req = 0; bus.calc_req = 0;
      bus4.evt_valid = 0; bus4.evt_cmd = 0; bus4.evt_hit = 0; bus4.clear_req = 0; bus4.calc_req = 0;
      model_zero();
      repeat (2) @(posedge clk);
      #1;
      chk_counts("reset");
      chk("reset.ratio", bus.ratio, 0);
      chk("reset.ratio_valid", bus.ratio_valid, 0);
      chk("reset.div_zero", bus.div_zero, 0);
      chk("reset.evt_ready", bus.evt_ready, 1);
      reset_n = 1;

      // 1: mixed classification, ratio 3/4
      step(1, 4'd0, 1, 0, 0); step(1, 4'd2, 1, 0, 0); step(1, 4'd1, 1, 0, 0);
      step(1, 4'd1, 0, 0, 0); step(1, 4'd3, 0, 0, 0);
      chk_counts("t1");
      step(0, 4'd0, 0, 0, 1);
      idle(12);
      chk("t1.ratio_hold", bus.ratio, 'h0C0);

      // 2: all hits, then clear and divide-by-zero
      step(0, 4'd0, 0, 1, 0);
      for (int i = 0; i < 5; i++) step(1, 4'd0, 1, 0, 0);
      step(0, 4'd0, 0, 0, 1);
      idle(12);
      chk("t2.ratio_full", bus.ratio, 'h100);
      chk("t2.div_zero", bus.div_zero, 0);
      step(0, 4'd0, 0, 1, 0);
      chk_counts("t2clr");
      chk("t2.ratio_clr", bus.ratio, 0);
      step(0, 4'd0, 0, 0, 1);
      idle(3);
      chk("t2.dz", bus.div_zero, 1);

      // 3: saturation on a 4-bit instance
      for (int i = 0; i < 17; i++) step4(1, 4'd0, 0, 0);
      chk("t3.reads", bus4.reads, 15);
      chk("t3.misses", bus4.misses, 15);
      chk("t3.sat", bus4.sat_flag, 1);
      step4(0, 4'd0, 0, 1);
      chk("t3.sat_clr", bus4.sat_flag, 0);
      chk("t3.reads_clr", bus4.reads, 0);

      // 4: events and a second calc during DIV
      step(0, 4'd0, 0, 1, 0);
      step(1, 4'd0, 1, 0, 0); step(1, 4'd0, 0, 0, 0); step(1, 4'd0, 0, 0, 0);
      step(0, 4'd0, 0, 0, 1);
      step(1, 4'd0, 1, 0, 0); step(1, 4'd0, 1, 0, 1);
      step(1, 4'd0, 1, 0, 0); step(1, 4'd0, 1, 0, 0);
      idle(12);
      chk("t4.ratio", bus.ratio, 'h055);
      chk("t4.hits", bus.hits, 5);
      chk_counts("t4");

      // 5: clear vs event, then clear aborting DIV
      bus.clear_req = 1; bus.evt_valid = 1; bus.evt_cmd = 0; bus.evt_hit = 1;
      #1;
      chk("t5.ready_low", bus.evt_ready, 0);
      step(1, 4'd0, 1, 1, 0);
      chk_counts("t5clr");
      step(1, 4'd0, 1, 0, 0);
      chk("t5.reads", bus.reads, 1);
      step(0, 4'd0, 0, 0, 1);
      idle(2);
      step(0, 4'd0, 0, 1, 0);
      chk("t5.busy_abort", bus.busy, 0);
      idle(12);

      // 6: asynchronous reset mid-DIV
      step(1, 4'd2, 1, 0, 0); step(1, 4'd1, 0, 0, 0); step(1, 4'd7, 0, 0, 0);
      step(0, 4'd0, 0, 0, 1);
      idle(3);
      #2;
      reset_n = 0;
      sbq.delete(); pend = 0; bz_on = 0; idle_from = 0; model_zero();
      #1;
      chk_counts("t6");
      chk("t6.busy", bus.busy, 0);
      chk("t6.ratio", bus.ratio, 0);
      chk("t6.evt_ready", bus.evt_ready, 1);
      @(posedge clk);
      #1;
      reset_n = 1;
      step(0, 4'd0, 0, 0, 1);
      idle(3);
      chk("t6.dz_idle", bus.div_zero, 1);

      // randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         bit clr, calc;
         clr  = ($urandom_range(0, 39) == 0);
         calc = !clr && ($urandom_range(0, 9) == 0);
         step($urandom_range(0, 1), 4'($urandom_range(0, 15)), $urandom_range(0, 1), clr, calc);
         if (i % 50 == 49) chk_counts("rand");
      end
      idle(15);
      chk_counts("final");
      chk("scoreboard_drained", sbq.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
